// File: rtl/btb_assoc.sv
// btb_assoc -- set-associative branch target buffer with misprediction stats.
//
// Looks up the fetch PC combinationally to steer the next PC and is trained
// from the execute stage with the resolved outcome of conditional branches.
// Each (set, way) holds valid, tag, target and a saturating counter; each set
// holds a round-robin victim pointer used once the set is full. Entries are
// only allocated for taken branches.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   PCF          fetch-stage PC to look up
//   PCE, OpE     execute-stage PC and opcode (training when OpE == BRANCH)
//   BranchE      resolved taken flag
//   BrNPC        resolved branch target
//   PredictedE   prediction flag that travelled with the EX instruction
//   PredPCE      predicted target that travelled with the EX instruction
//   FlushAll     synchronous invalidate of every entry
//   PredictedF   predict taken for PCF
//   PredictedPC  predicted target (0 when PredictedF = 0)
//   BranchCnt    trained-branch count (wraps)
//   MispredCnt   mispredicted-branch count (wraps)
module btb_assoc #(
  parameter int INDEX_LEN = 4,
  parameter int WAYS      = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic [6:0]  OpE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  input  logic        PredictedE,
  input  logic [31:0] PredPCE,
  input  logic        FlushAll,
  output logic        PredictedF,
  output logic [31:0] PredictedPC,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int SETS  = 2 ** INDEX_LEN;
  localparam int TAG_W = 32 - INDEX_LEN - 2;
  // A 1-way table still carries a 1-bit pointer; it is simply never advanced.
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [6:0]       OP_BRANCH = 7'b110_0011;
  localparam logic [CNT_W-1:0] CNT_WEAK  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Table state
  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];
  logic [CNT_W-1:0] cnt_q   [SETS][WAYS];
  logic [PTR_W-1:0] ptr_q   [SETS];

  // Statistics
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // The two low PC bits never address anything (instructions are word aligned).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [INDEX_LEN-1:0] set_f;
  logic [TAG_W-1:0]     tag_f;
  logic                 hit_f;
  logic [PTR_W-1:0]     way_f;

  assign set_f = PCF[INDEX_LEN+1:2];
  assign tag_f = PCF[31:INDEX_LEN+2];

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_f = 1'b0;
    way_f = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_f][w] && (tag_q[set_f][w] == tag_f)) begin
        hit_f = 1'b1;
        way_f = PTR_W'(w);
      end
    end
  end

  assign PredictedF  = hit_f && cnt_q[set_f][way_f][CNT_W-1];
  assign PredictedPC = PredictedF ? tgt_q[set_f][way_f] : 32'h0;

  // -------------------------------------------------------------- training
  logic [INDEX_LEN-1:0] set_e;
  logic [TAG_W-1:0]     tag_e;
  logic                 train;
  logic                 mispred;
  logic                 hit_e;
  logic [PTR_W-1:0]     way_e;
  logic                 free_found;
  logic [PTR_W-1:0]     free_way;
  logic [PTR_W-1:0]     victim_way;

  assign set_e = PCE[INDEX_LEN+1:2];
  assign tag_e = PCE[31:INDEX_LEN+2];
  assign train = (OpE == OP_BRANCH);

  // A taken branch with the right direction still mispredicts on a stale target.
  assign mispred = (BranchE != PredictedE) ||
                   (BranchE && PredictedE && (PredPCE != BrNPC));

  always_comb begin
    hit_e      = 1'b0;
    way_e      = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_e][w] && (tag_q[set_e][w] == tag_e)) begin
        hit_e = 1'b1;
        way_e = PTR_W'(w);
      end
      // First invalid way in ascending order = lowest-numbered free way.
      if (!valid_q[set_e][w] && !free_found) begin
        free_found = 1'b1;
        free_way   = PTR_W'(w);
      end
    end
  end

  assign victim_way = free_found ? free_way : ptr_q[set_e];

  // Statistics count every training cycle, including one that a flush overrides.
  assign branch_cnt_d  = train ? branch_cnt_q + 32'd1 : branch_cnt_q;
  assign mispred_cnt_d = (train && mispred) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and the lookup sees the old entry on a same-cycle
  // PCF/PCE collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is a flop array rather than a RAM macro, so every entry
      // (not just the valid bits) is cleared to give a fully defined state.
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          cnt_q[s][w]   <= '0;
        end
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;

      if (FlushAll) begin
        // Counters and targets survive a flush; only validity and pointers go.
        for (int s = 0; s < SETS; s++) begin
          ptr_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            valid_q[s][w] <= 1'b0;
          end
        end
      end else if (train) begin
        if (hit_e) begin
          if (BranchE) begin
            if (cnt_q[set_e][way_e] != CNT_MAX) begin
              cnt_q[set_e][way_e] <= cnt_q[set_e][way_e] + 1'b1;
            end
            tgt_q[set_e][way_e] <= BrNPC;
          end else if (cnt_q[set_e][way_e] != '0) begin
            cnt_q[set_e][way_e] <= cnt_q[set_e][way_e] - 1'b1;
          end
        end else if (BranchE) begin
          valid_q[set_e][victim_way] <= 1'b1;
          tag_q[set_e][victim_way]   <= tag_e;
          tgt_q[set_e][victim_way]   <= BrNPC;
          cnt_q[set_e][victim_way]   <= CNT_WEAK;
          // WAYS is a power of two, so the natural wrap of the pointer is mod WAYS.
          if (!free_found && (WAYS > 1)) begin
            ptr_q[set_e] <= ptr_q[set_e] + 1'b1;
          end
        end
      end
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc -- self-checking bench for btb_assoc (INDEX_LEN=4, WAYS=2, CNT_W=2).
// Each table row drives one cycle; outputs are sampled before the edge, so a
// row's expectations reflect the state left by the rows before it.
module tb_btb_assoc;

  localparam logic [6:0] OP_BR = 7'b110_0011;
  localparam logic [6:0] OP_NB = 7'b011_0011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, BrNPC, PredPCE;
  logic [6:0]  OpE;
  logic        BranchE, PredictedE, FlushAll;
  logic        PredictedF;
  logic [31:0] PredictedPC, BranchCnt, MispredCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btb_assoc #(.INDEX_LEN(4), .WAYS(2), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .PCE        (PCE),
    .OpE        (OpE),
    .BranchE    (BranchE),
    .BrNPC      (BrNPC),
    .PredictedE (PredictedE),
    .PredPCE    (PredPCE),
    .FlushAll   (FlushAll),
    .PredictedF (PredictedF),
    .PredictedPC(PredictedPC),
    .BranchCnt  (BranchCnt),
    .MispredCnt (MispredCnt)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        train;
    logic [31:0] pce;
    logic        br;
    logic [31:0] npc;
    logic        pe;
    logic [31:0] ppce;
    logic        flush;
    logic        exp_pf;
    logic [31:0] exp_ppc;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pcf, input logic train, input logic [31:0] pce,
                     input logic br, input logic [31:0] npc, input logic pe,
                     input logic [31:0] ppce, input logic flush, input logic exp_pf,
                     input logic [31:0] exp_ppc, input logic [31:0] exp_bc,
                     input logic [31:0] exp_mc);
    vec_t v;
    v.pcf = pcf; v.train = train; v.pce = pce; v.br = br; v.npc = npc;
    v.pe = pe; v.ppce = ppce; v.flush = flush; v.exp_pf = exp_pf;
    v.exp_ppc = exp_ppc; v.exp_bc = exp_bc; v.exp_mc = exp_mc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] pcf, input logic train, input logic [31:0] pce,
                       input logic br, input logic [31:0] npc, input logic pe,
                       input logic [31:0] ppce, input logic flush);
    PCF = pcf; OpE = train ? OP_BR : OP_NB; PCE = pce; BranchE = br;
    BrNPC = npc; PredictedE = pe; PredPCE = ppce; FlushAll = flush;
  endtask

  task automatic check_out(input string tag, input logic pf, input logic [31:0] ppc,
                           input logic [31:0] bc, input logic [31:0] mc);
    check({tag, " PredictedF"},  {31'b0, PredictedF}, {31'b0, pf});
    check({tag, " PredictedPC"}, PredictedPC, ppc);
    check({tag, " BranchCnt"},   BranchCnt, bc);
    check({tag, " MispredCnt"},  MispredCnt, mc);
  endtask

  initial begin
    //   pcf    trn pce    br npc    pe ppce  fl | pf ppc    bc  mc
    // Reset state and first allocation (same-cycle lookup sees old state).
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  0, 32'h00, 0, 0);
    add(32'h100, 1, 32'h100, 1, 32'h080, 0, 32'h00, 0,  0, 32'h00, 0, 0);
    // Counter walk 10 -> 01 -> 00 -> 01 -> 10.
    add(32'h100, 1, 32'h100, 0, 32'h104, 1, 32'h80, 0,  1, 32'h80, 1, 1);
    add(32'h100, 1, 32'h100, 0, 32'h104, 0, 32'h00, 0,  0, 32'h00, 2, 2);
    add(32'h100, 1, 32'h100, 1, 32'h080, 0, 32'h00, 0,  0, 32'h00, 3, 2);
    add(32'h100, 1, 32'h100, 1, 32'h080, 0, 32'h00, 0,  0, 32'h00, 4, 3);
    // Non-branch opcode with BranchE=1 and a different target: no change.
    add(32'h100, 0, 32'h100, 1, 32'h200, 0, 32'h00, 0,  1, 32'h80, 5, 4);
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  1, 32'h80, 5, 4);
    // Fill set 0, then evict via round-robin pointer.
    add(32'h140, 1, 32'h140, 1, 32'h0A0, 0, 32'h00, 0,  0, 32'h00, 5, 4);
    add(32'h100, 1, 32'h180, 1, 32'h0C0, 0, 32'h00, 0,  1, 32'h80, 6, 5);
    add(32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  0, 32'h00, 7, 6);
    add(32'h140, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  1, 32'hA0, 7, 6);
    add(32'h180, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  1, 32'hC0, 7, 6);
    add(32'h1C0, 1, 32'h1C0, 1, 32'h0E0, 0, 32'h00, 0,  0, 32'h00, 7, 6);
    add(32'h140, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  0, 32'h00, 8, 7);
    add(32'h1C0, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  1, 32'hE0, 8, 7);
    // Wrong target with right direction, then correct prediction (saturates).
    add(32'h180, 1, 32'h180, 1, 32'h090, 1, 32'h80, 0,  1, 32'hC0, 8, 7);
    add(32'h180, 1, 32'h180, 1, 32'h090, 1, 32'h90, 0,  1, 32'h90, 9, 8);
    // Flush together with a taken update: flush wins, stats still count.
    add(32'h180, 1, 32'h1C0, 1, 32'h0E0, 1, 32'hE0, 1,  1, 32'h90, 10, 8);
    add(32'h180, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  0, 32'h00, 11, 8);
    add(32'h1C0, 0, 32'h000, 0, 32'h000, 0, 32'h00, 0,  0, 32'h00, 11, 8);

    drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pcf, vecs[i].train, vecs[i].pce, vecs[i].br, vecs[i].npc,
            vecs[i].pe, vecs[i].ppce, vecs[i].flush);
      #1;
      check_out($sformatf("row%0d", i), vecs[i].exp_pf, vecs[i].exp_ppc,
                vecs[i].exp_bc, vecs[i].exp_mc);
      @(negedge clk);
    end

    // Wrap: preload the branch counter to all-ones, then train one branch.
    drive(32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    force dut.branch_cnt_d = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.branch_cnt_d;
    #1;
    check("wrap preload BranchCnt", BranchCnt, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(32'h300, 1, 32'h300, 0, 32'h304, 0, 32'h0, 0);
    @(negedge clk);
    drive(32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check_out("wrap", 1'b0, 32'h0, 32'h0, 32'd8);

    // Allocate in set 1, then assert reset asynchronously with an update pending.
    @(negedge clk);
    drive(32'h104, 1, 32'h104, 1, 32'h044, 0, 32'h0, 0);
    @(negedge clk);
    drive(32'h104, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check_out("set1 alloc", 1'b1, 32'h44, 32'd1, 32'd9);
    @(negedge clk);
    drive(32'h104, 1, 32'h104, 1, 32'h048, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    check_out("async reset", 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h104, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check_out("post reset", 1'b0, 32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
